// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for the single-port sort RAM.
// Requester 0 is the sort datapath, requester 1 the host port; a lock holds the port for swaps.
module ram_port_arbiter #(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 8,
  parameter int LOCK_MAX  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req0,
  input  logic                 i_req1,
  input  logic                 i_lock0,
  input  logic                 i_lock1,
  input  logic                 i_wr_en0,
  input  logic                 i_wr_en1,
  input  logic [SIZE_ADDR-1:0] i_addr0,
  input  logic [SIZE_ADDR-1:0] i_addr1,
  input  logic [SIZE_DATA-1:0] i_data0,
  input  logic [SIZE_DATA-1:0] i_data1,
  output logic                 o_gnt0,
  output logic                 o_gnt1,
  output logic                 o_rvalid0,
  output logic                 o_rvalid1,
  output logic [SIZE_DATA-1:0] o_rdata,
  output logic [1:0]           o_lock_abort,
  output logic                 o_ram_rd_en,
  output logic                 o_ram_wr_en,
  output logic [SIZE_ADDR-1:0] o_ram_addr,
  output logic [SIZE_DATA-1:0] o_ram_data,
  input  logic [SIZE_DATA-1:0] i_ram_data
);

  // state | meaning
  // IDLE  | no owner; grant by single request or rr_ptr
  // OWN0  | requester 0 holds a lock; only it may be granted
  // OWN1  | requester 1 holds a lock; only it may be granted
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             rr_ptr;
  logic [CNT_W-1:0] lock_cnt;
  logic             own_id;
  logic             own_req;
  logic             own_lock;
  logic             own_gnt;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_rst_n) begin
      case (state)
        IDLE: begin
          if (i_req0 && i_req1) begin
            o_gnt0 = ~rr_ptr;
            o_gnt1 = rr_ptr;
          end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
          end
        end
        OWN0:    o_gnt0 = i_req0;
        OWN1:    o_gnt1 = i_req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ram_rd_en = 1'b0;
    o_ram_wr_en = 1'b0;
    o_ram_addr  = '0;
    o_ram_data  = '0;
    if (o_gnt0) begin
      o_ram_rd_en = ~i_wr_en0;
      o_ram_wr_en = i_wr_en0;
      o_ram_addr  = i_addr0;
      o_ram_data  = i_data0;
    end else if (o_gnt1) begin
      o_ram_rd_en = ~i_wr_en1;
      o_ram_wr_en = i_wr_en1;
      o_ram_addr  = i_addr1;
      o_ram_data  = i_data1;
    end
  end

  assign own_id   = (state == OWN1);
  assign own_req  = own_id ? i_req1  : i_req0;
  assign own_lock = own_id ? i_lock1 : i_lock0;
  assign own_gnt  = own_id ? o_gnt1  : o_gnt0;
  assign o_rdata  = i_ram_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      lock_cnt     <= '0;
      o_rvalid0    <= 1'b0;
      o_rvalid1    <= 1'b0;
      o_lock_abort <= 2'b00;
    end else begin
      o_rvalid0    <= o_gnt0 & ~i_wr_en0;
      o_rvalid1    <= o_gnt1 & ~i_wr_en1;
      o_lock_abort <= 2'b00;
      case (state)
        IDLE: begin
          if (o_gnt0) begin
            if (i_lock0) begin
              state    <= OWN0;
              lock_cnt <= CNT_ONE;
            end else begin
              rr_ptr <= 1'b1;
            end
          end else if (o_gnt1) begin
            if (i_lock1) begin
              state    <= OWN1;
              lock_cnt <= CNT_ONE;
            end else begin
              rr_ptr <= 1'b0;
            end
          end
        end
        OWN0, OWN1: begin
          // A voluntary release in the timeout cycle is not reported as an abort.
          if (own_gnt && !own_lock) begin
            state    <= IDLE;
            rr_ptr   <= ~own_id;
            lock_cnt <= '0;
          end else if (!own_req && !own_lock) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (lock_cnt == CNT_MAX) begin
            state        <= IDLE;
            rr_ptr       <= ~own_id;
            lock_cnt     <= '0;
            o_lock_abort <= own_id ? 2'b10 : 2'b01;
          end else begin
            lock_cnt <= lock_cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios, a RAM model, and a per-cycle ownership model.
module tb_ram_port_arbiter;
  localparam int LM = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req0, i_req1, i_lock0, i_lock1, i_wr_en0, i_wr_en1;
  logic [7:0] i_addr0, i_addr1, i_data0, i_data1;
  logic       o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
  logic [7:0] o_rdata;
  logic [1:0] o_lock_abort;
  logic       o_ram_rd_en, o_ram_wr_en;
  logic [7:0] o_ram_addr, o_ram_data, i_ram_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];

  ram_port_arbiter #(.SIZE_ADDR(8), .SIZE_DATA(8), .LOCK_MAX(LM)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_req1(i_req1), .i_lock0(i_lock0), .i_lock1(i_lock1),
    .i_wr_en0(i_wr_en0), .i_wr_en1(i_wr_en1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_data0(i_data0), .i_data1(i_data1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata(o_rdata), .o_lock_abort(o_lock_abort),
    .o_ram_rd_en(o_ram_rd_en), .o_ram_wr_en(o_ram_wr_en),
    .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data), .i_ram_data(i_ram_data)
  );

  always #5 i_clk = ~i_clk;

  // RAM: contents re-seeded to addr ^ 0x39 during reset (so RAM[5] = 0x3C).
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h39;
    end else begin
      if (o_ram_wr_en) mem[o_ram_addr] <= o_ram_data;
      if (o_ram_rd_en) i_ram_data <= mem[o_ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: owner -1 = nobody, held = locked cycles counted since the lock was taken.
  int         owner = -1;
  int         held  = 0;
  int         rr    = 0;
  logic       m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [1:0] m_abort = 2'b00;
  logic [7:0] ref_mem [256];

  always @(negedge i_clk) begin
    logic eg0, eg1, g, lk, rq, wr;
    logic [7:0] a, d;
    int k;
    check("rvalid0", o_rvalid0, m_rv0);
    check("rvalid1", o_rvalid1, m_rv1);
    if (m_rv0 || m_rv1) check("rdata", o_rdata, m_rdata);
    check("lock_abort", o_lock_abort, m_abort);

    eg0 = 1'b0; eg1 = 1'b0;
    if (i_rst_n) begin
      if (owner == 0) eg0 = i_req0;
      else if (owner == 1) eg1 = i_req1;
      else if (i_req0 && i_req1) begin
        eg0 = (rr == 0); eg1 = (rr == 1);
      end else begin
        eg0 = i_req0; eg1 = i_req1;
      end
    end
    wr = eg0 ? i_wr_en0 : (eg1 ? i_wr_en1 : 1'b0);
    a  = eg0 ? i_addr0  : (eg1 ? i_addr1  : 8'h00);
    d  = eg0 ? i_data0  : (eg1 ? i_data1  : 8'h00);
    check("gnt0", o_gnt0, eg0);
    check("gnt1", o_gnt1, eg1);
    check("ram_rd_en", o_ram_rd_en, (eg0 || eg1) && !wr);
    check("ram_wr_en", o_ram_wr_en, (eg0 || eg1) && wr);
    check("ram_addr", o_ram_addr, a);
    check("ram_data", o_ram_data, d);

    if (!i_rst_n) begin
      owner = -1; held = 0; rr = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_abort = 2'b00;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h39;
    end else begin
      m_abort = 2'b00;
      m_rv0 = eg0 && !i_wr_en0;
      m_rv1 = eg1 && !i_wr_en1;
      if ((eg0 || eg1) && !wr) m_rdata = ref_mem[a];
      if ((eg0 || eg1) && wr) ref_mem[a] = d;
      if (owner < 0) begin
        if (eg0 || eg1) begin
          k  = eg1 ? 1 : 0;
          lk = eg1 ? i_lock1 : i_lock0;
          if (lk) begin owner = k; held = 1; end
          else rr = 1 - k;
        end
      end else begin
        k  = owner;
        g  = (k == 1) ? eg1 : eg0;
        lk = (k == 1) ? i_lock1 : i_lock0;
        rq = (k == 1) ? i_req1 : i_req0;
        if (g && !lk) begin owner = -1; rr = 1 - k; end
        else if (!rq && !lk) owner = -1;
        else if (held == LM) begin
          owner = -1; rr = 1 - k; m_abort = (k == 1) ? 2'b10 : 2'b01;
        end else held++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge i_clk); #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_req0 = 0; i_req1 = 0; i_lock0 = 0; i_lock1 = 0; i_wr_en0 = 0; i_wr_en1 = 0;
    i_addr0 = 0; i_addr1 = 0; i_data0 = 0; i_data1 = 0;
  endtask

  initial begin
    idle_inputs();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    sample();
    check("reset_gnt", {o_gnt1, o_gnt0}, 2'b00);
    check("reset_rvalid", {o_rvalid1, o_rvalid0}, 2'b00);

    // Single host read of addr 5
    next_cycle(); i_req1 = 1; i_addr1 = 8'h05;
    sample(); check("t1_gnt1", o_gnt1, 1); check("t1_rd_en", o_ram_rd_en, 1);
    next_cycle(); idle_inputs();
    sample(); check("t1_rvalid1", o_rvalid1, 1); check("t1_rdata", o_rdata, 8'h3C);

    // Both requesting unlocked reads: strict alternation from requester 0
    for (int i = 0; i < 4; i++) begin
      next_cycle(); i_req0 = 1; i_req1 = 1; i_addr0 = 8'(i); i_addr1 = 8'(i + 16);
      sample();
      check("t2_gnt0", o_gnt0, (i % 2) == 0);
      check("t2_gnt1", o_gnt1, (i % 2) == 1);
    end
    next_cycle(); idle_inputs();

    // Locked swap by requester 0 while the host waits
    next_cycle(); i_req1 = 1; i_addr1 = 8'h09;
    i_req0 = 1; i_lock0 = 1; i_addr0 = 8'h02;
    sample(); check("t3_gnt1_c1", o_gnt1, 0); check("t3_gnt0_c1", o_gnt0, 1);
    next_cycle(); i_addr0 = 8'h07;
    sample(); check("t3_gnt1_c2", o_gnt1, 0);
    next_cycle(); i_wr_en0 = 1; i_addr0 = 8'h02; i_data0 = 8'h11;
    sample(); check("t3_gnt1_c3", o_gnt1, 0);
    next_cycle(); i_addr0 = 8'h07; i_data0 = 8'h22; i_lock0 = 0;
    sample(); check("t3_gnt1_c4", o_gnt1, 0); check("t3_wr_en", o_ram_wr_en, 1);
    next_cycle(); i_req0 = 0; i_wr_en0 = 0;
    sample(); check("t3_gnt1_c5", o_gnt1, 1);
    check("t3_mem2", mem[2], 8'h11); check("t3_mem7", mem[7], 8'h22);
    next_cycle(); idle_inputs();

    // Lock timeout: requester 0 never releases
    next_cycle(); i_req0 = 1; i_lock0 = 1; i_req1 = 1; i_addr0 = 8'h30; i_addr1 = 8'h31;
    for (int i = 0; i < LM + 1; i++) begin
      sample();
      check("t4_gnt0_held", o_gnt0, 1);
      check("t4_no_abort", o_lock_abort, 2'b00);
      next_cycle();
    end
    sample(); check("t4_abort", o_lock_abort, 2'b01); check("t4_gnt1", o_gnt1, 1);
    next_cycle(); idle_inputs();
    sample(); check("t4_abort_clear", o_lock_abort, 2'b00);

    // Reset while requester 1 owns the port with a read in flight
    next_cycle(); i_req1 = 1; i_lock1 = 1; i_addr1 = 8'h05;
    next_cycle(); i_rst_n = 0;
    sample(); check("t5_gnt_in_rst", o_gnt1, 0);
    next_cycle(); i_rst_n = 1; i_lock1 = 0; i_req0 = 1; i_addr0 = 8'h06;
    sample();
    check("t5_no_rvalid", {o_rvalid1, o_rvalid0}, 2'b00);
    check("t5_gnt0_first", o_gnt0, 1); check("t5_gnt1_held", o_gnt1, 0);
    next_cycle(); idle_inputs();

    // Host writes 0xA5 at 0xFF, sorter reads it back
    next_cycle(); i_req1 = 1; i_wr_en1 = 1; i_addr1 = 8'hFF; i_data1 = 8'hA5;
    next_cycle(); idle_inputs(); i_req0 = 1; i_addr0 = 8'hFF;
    next_cycle(); idle_inputs();
    sample();
    check("t6_rvalid0", o_rvalid0, 1); check("t6_rdata", o_rdata, 8'hA5);
    check("t6_rvalid1", o_rvalid1, 0);

    repeat (3) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
